// File: rtl/softmax_seq_ctrl.sv
// Sequencing controller for a softmax front end: buffers one score vector, tracks its
// maximum, then streams each (score - max) through a shared exp unit into an output register.
module softmax_seq_ctrl #(
  parameter int unsigned N_MAX = 16,
  parameter int unsigned AW    = $clog2(N_MAX)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_x,
  input  logic        in_last,
  output logic [16:0] exp_x,
  input  logic [20:0] exp_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] out_exp,
  output logic        out_last,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, EXP, DRAIN} state_e;

  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LEN_TOP = (AW+1)'(N_MAX - 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  // -10.0 in Q4.12 two's complement, the saturation floor of the difference
  localparam logic signed [17:0] D_MIN = -18'sd40960;

  state_e          state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [16:0]     max_q, max_d;
  logic            out_valid_q, out_valid_d;
  logic [20:0]     out_exp_q, out_exp_d;
  logic            out_last_q, out_last_d;
  logic            ovf_q, ovf_d;

  logic [16:0]     buf_q [N_MAX];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  logic            in_fire;
  logic            last_elem;
  logic signed [17:0] in_tc, max_tc, cur_tc, diff, diff_sat;

  function automatic logic signed [17:0] sm2tc(input logic [16:0] x);
    logic signed [17:0] m;
    m = signed'({2'b00, x[15:0]});
    return x[16] ? -m : m;
  endfunction

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_exp   = out_exp_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;
  assign last_elem = ({1'b0, rd_ptr_q} == (len_q - LEN_ONE));

  always_comb begin
    in_tc    = sm2tc(in_x);
    max_tc   = sm2tc(max_q);
    cur_tc   = sm2tc(buf_q[rd_ptr_q]);
    diff     = cur_tc - max_tc;
    diff_sat = (diff < D_MIN) ? D_MIN : diff;
    exp_x    = '0;
    // a zero difference is always encoded +0, never -0
    if ((state_q == EXP) && (diff_sat != 18'sd0))
      exp_x = {1'b1, 16'(-diff_sat)};
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_exp_d   = out_exp_q;
    out_last_d  = out_last_q;
    ovf_d       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = len_q[AW-1:0];
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          max_d   = in_x;
          len_d   = LEN_ONE;
          state_d = in_last ? EXP : LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          wr_en = 1'b1;
          len_d = len_q + LEN_ONE;
          if (in_tc > max_tc)
            max_d = in_x;
          if (in_last) begin
            state_d = EXP;
          end else if (len_q == LEN_TOP) begin
            // buffer full: close the vector and flag truncation
            state_d = EXP;
            ovf_d   = 1'b1;
          end
        end
      end
      EXP: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_exp_d   = exp_y;
          out_last_d  = last_elem;
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          if (last_elem)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            rd_ptr_d = '0;
            len_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_exp_q   <= '0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_exp_q   <= out_exp_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      buf_q[wr_addr] <= in_x;
  end

endmodule

// File: doc/softmax_seq_ctrl.md
SOFTMAX_SEQ_CTRL -- requirements
Module: softmax_seq_ctrl

Interface
REQ-001 Parameter N_MAX, default 16, SHALL set the maximum vector length; it is a power of two, at least 2.
REQ-002 Parameter AW, default $clog2(N_MAX), SHALL set the buffer address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 in_valid / in_ready  input / output  1 / 1  SHALL form the score input handshake; a beat transfers when both are high.
REQ-006 in_x  input  17  SHALL carry the score in sign-magnitude: bit16 sign, bits15:12 integer magnitude, bits11:0 fraction.
REQ-007 in_last  input  1  SHALL mark the final beat of a vector.
REQ-008 exp_x  output  17  SHALL drive the operand of the shared combinational exp unit, in the same format as in_x.
REQ-009 exp_y  input  21  SHALL return the exp unit result, {5-bit position, 16-bit mantissa}, valid in the same cycle as exp_x.
REQ-010 out_valid / out_ready  output / input  1 / 1  SHALL form the result output handshake.
REQ-011 out_exp  output  21  SHALL carry the registered exp_y for one element.
REQ-012 out_last  output  1  SHALL mark the final result of a vector.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 ovf  output  1  SHALL pulse high for one cycle when a vector is truncated at N_MAX.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, EXP and DRAIN.
REQ-016 in_ready SHALL be 1 in IDLE and LOAD, and 0 in EXP and DRAIN.
REQ-017 IDLE: an accepted beat SHALL be written to buf[0], set max=in_x and len=1, then go to LOAD, or to EXP if in_last=1.
REQ-018 LOAD: each accepted beat SHALL be written to buf[len], increment len, and replace max when in_x is greater (sign-magnitude compare; -0 equals +0).
REQ-019 LOAD: an accepted beat with in_last=1 SHALL transition to EXP.
REQ-020 A beat accepted when len==N_MAX-1 without in_last SHALL be treated as last: transition to EXP and pulse ovf in the following cycle.
REQ-021 While in EXP, exp_x SHALL be combinational from buf[rd_ptr].
REQ-022 The difference d = buf[rd_ptr] - max SHALL be computed in 18-bit two's complement; d is always <= 0.
REQ-023 If d < -10.0, d SHALL be saturated to -10.0.
REQ-024 exp_x SHALL be 17'h00000 when d==0 (never 17'h10000); otherwise exp_x = {1'b1, |d|[15:0]}.
REQ-025 exp_x SHALL be 17'h00000 outside EXP.
REQ-026 EXP: when out_valid==0 or out_ready==1, the block SHALL load out_exp<=exp_y, set out_valid<=1, set out_last<=(rd_ptr==len-1), and increment rd_ptr.
REQ-027 EXP: loading the element with rd_ptr==len-1 SHALL transition to DRAIN.
REQ-028 EXP: when the output register is occupied and out_ready==0, rd_ptr, out_exp and out_last SHALL hold.
REQ-029 DRAIN: acceptance of the out_last beat SHALL clear out_valid, clear rd_ptr and len, and go to IDLE.
REQ-030 In all other states, an output handshake with no new load SHALL clear out_valid.
REQ-031 Latency: the first out_valid SHALL rise at the rising edge following the edge that accepted the last input beat.
REQ-032 With out_ready held high, throughput SHALL be 1 result per cycle; a vector of L results SHALL complete in L cycles after entering EXP.
REQ-033 out_exp and out_last SHALL remain stable while out_valid==1 and out_ready==0.
REQ-034 max SHALL be recomputed for every vector; no state beyond what is cleared on return to IDLE SHALL carry over between vectors.

Reset
REQ-035 While rst is high, the block SHALL force state=IDLE, len=0, rd_ptr=0, max=0, out_valid=0, out_exp=0, out_last=0, ovf=0 and busy=0.
REQ-036 Buffer contents SHALL not require reset.
REQ-037 Reset asserted mid-LOAD, EXP or DRAIN SHALL discard the vector.
REQ-038 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-039 Scores {+1.0, +3.0, -2.0} (17'h01000, 17'h03000, 17'h12000), last on the 3rd beat -> exp_x sequence 17'h12000, 17'h00000, 17'h15000; out_exp equals the bench model's exp_y for each, in order; out_last on the 3rd result.
REQ-040 Scores {+9.0, -9.0} -> exp_x sequence 17'h00000, 17'h1A000 (saturated at -10.0).
REQ-041 Single beat 17'h1F000 with in_last -> exactly one result with exp_x=17'h00000, out_last=1; out_valid at the next edge.
REQ-042 out_ready held low for 5 cycles mid-vector -> out_exp and out_last stable; no element skipped or duplicated; in_ready stays 0.
REQ-043 17 beats offered with in_last never set -> 16 accepted, ovf pulses once, 16 results with out_last on the 16th; the 17th beat is accepted only after return to IDLE.
REQ-044 rst pulsed during EXP after 2 of 4 results -> out_valid=0 immediately; next vector of length 1 produces exactly one result.
